fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's dual-clock FIFO among N_REQ write-side requesters.
- Round-robin arbitration with burst locking: the owner keeps the port until it marks a last beat or hits MAX_BURST beats.
- Lives entirely in the clk_wr domain and drives the FIFO's we/data_in directly.
- Honours the FIFO's registered, look-ahead full flag, so no overflow write is ever issued.

---
 rtl/fifo_arb_pkg.sv | 37 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO-side round-robin arbiters.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam logic [15:0] SAT_MAX    = 16'hFFFF;
    localparam int unsigned RR_MAX_REQ = 8;

    // First set bit of valid searching upward from last+1, modulo n (n <= 8).
    // Returns last when nothing is valid; callers gate with |valid.
    function automatic logic [2:0] rr_next_idx(
        input logic [7:0] valid,
        input logic [2:0] last,
        input logic [3:0] n
    );
        logic [2:0] res;
        logic [3:0] cand;
        logic       found;
        res   = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            cand = {1'b0, last} + 4'(k);
            if (cand >= n) begin
                cand = cand - n;
            end
            if (!found && (4'(k) <= n) && valid[cand[2:0]]) begin
                res   = cand[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot and index of the next valid
// requester after last_owner. Usable by read- and write-side arbiters.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [7:0] valid8;
    logic [2:0] pick3;

    always_comb begin
        valid8              = '0;
        valid8[N_REQ-1:0]   = valid;
        pick3               = rr_next_idx(valid8, 3'(last_owner), 4'(N_REQ));
        idx                 = pick3[IDX_W-1:0];
        any                 = |valid;
        onehot              = '0;
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharer of the dual-clock FIFO write port (clk_wr domain).
// Optional FIFO_WR_ARB_STATS_EN adds saturating beat_total / stall_cnt counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk_wr,
    input  logic                   rst,
    input  logic                   chip_en,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic [WIDTH-1:0]       fifo_data,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]            beat_total,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BCW   = $clog2(MAX_BURST) + 1;

    // Handshake: a beat moves when req_valid[i] & req_ready[i]; ready never
    // depends on valid, only on the registered grant, fifo_full and chip_en.
    arb_state_t       state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [IDX_W-1:0] last_owner, last_owner_n;
    logic [IDX_W-1:0] owner_idx, owner_idx_n;
    logic [BCW-1:0]   beat_cnt, beat_cnt_n;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             own_valid;
    logic             own_last;
    logic             release_burst;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_owner (last_owner),
        .onehot     (pick_onehot),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign own_valid     = req_valid[owner_idx];
    assign own_last      = req_last[owner_idx];
    assign release_burst = fifo_we && (own_last || (beat_cnt == BCW'(MAX_BURST - 1)));

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
            owner_idx  <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_owner <= last_owner_n;
            owner_idx  <= owner_idx_n;
            beat_cnt   <= beat_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_owner_n = last_owner;
        owner_idx_n  = owner_idx;
        beat_cnt_n   = beat_cnt;
        if (chip_en) begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_n     = pick_onehot;
                        owner_idx_n = pick_idx;
                        beat_cnt_n  = '0;
                        state_n     = ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    // The lock holds even while the owner drops valid.
                    if (fifo_we) begin
                        beat_cnt_n = beat_cnt + BCW'(1);
                    end
                    if (release_burst) begin
                        grant_n      = '0;
                        last_owner_n = owner_idx;
                        state_n      = ARB_IDLE;
                    end
                end
                default: state_n = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == ARB_BURST);
        req_ready = grant & {N_REQ{~fifo_full & chip_en}};
        fifo_we   = |(req_valid & req_ready);
        fifo_data = '0;
        if (|grant) begin
            fifo_data = req_data[int'(owner_idx)*WIDTH +: WIDTH];
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            beat_total <= '0;
            stall_cnt  <= '0;
        end else begin
            if (fifo_we && (beat_total != SAT_MAX)) begin
                beat_total <= beat_total + 16'd1;
            end
            if (chip_en && busy && own_valid && fifo_full && (stall_cnt != SAT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed steps plus random traffic against a
// cycle-level reference model and an expected-write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic             clk_wr = 1'b0;
    logic             rst;
    logic             chip_en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_we;
    logic [W-1:0]     fifo_data;
    logic [N-1:0]     grant;
    logic             busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]      beat_total;
    logic [15:0]      stall_cnt;
`endif

    always #5 clk_wr = ~clk_wr;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_wr    (clk_wr),
        .rst       (rst),
        .chip_en   (chip_en),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_data (fifo_data),
        .grant     (grant),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_total (beat_total),
        .stall_cnt  (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: owner (-1 when nobody holds the port), rotation
    // pointer, beats granted so far and stats totals.
    int m_owner;
    int m_last;
    int m_beats;
    int m_total;
    int m_stall;

    int           start_q[$];
    int           we_per_req[N];
    int           idle_cycles;
    logic         rec;
    logic [N-1:0] prev_grant;

    logic [N-1:0] obs_grant;
    logic [N-1:0] obs_ready;
    logic         obs_we;
    logic         obs_busy;
    logic [W-1:0] obs_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
        m_total = 0;
        m_stall = 0;
        exp_q.delete();
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_xfer;
        logic [W-1:0] e_data;
        logic [W-1:0] got;
        int           g;
        @(negedge clk_wr);
        e_grant = '0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_data           = req_data[m_owner*W +: W];
        end
        e_ready = (!fifo_full && chip_en) ? e_grant : '0;
        e_xfer  = |(e_ready & req_valid);

        obs_grant = grant;
        obs_ready = req_ready;
        obs_we    = fifo_we;
        obs_busy  = busy;
        obs_data  = fifo_data;
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("fifo_we", 32'(fifo_we), 32'(e_xfer));
        check("fifo_data", 32'(fifo_data), 32'(e_data));

        if (e_xfer) exp_q.push_back(e_data);
        if (fifo_we) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("sb_data", 32'(fifo_data), 32'(got));
            end
        end

        if (rec) begin
            g = idx_of(grant);
            if (grant != '0 && prev_grant == '0) start_q.push_back(g);
            if (fifo_we && g >= 0) we_per_req[g]++;
            if (grant == '0) idle_cycles++;
        end
        prev_grant = grant;

        @(posedge clk_wr);
        if (e_xfer) m_total++;
        if (chip_en && m_owner >= 0 && req_valid[m_owner] && fifo_full) m_stall++;
        if (chip_en) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req_valid[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_beats = 0;
                    end
                end
            end else if (e_xfer) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        #1;
    endtask

    task automatic clear_rec();
        start_q.delete();
        for (int i = 0; i < N; i++) we_per_req[i] = 0;
        idle_cycles = 0;
    endtask

    // Let the current owner finish with a last beat, bounded.
    task automatic drain();
        for (int c = 0; c < 20 && m_owner >= 0; c++) begin
            req_valid          = '0;
            req_valid[m_owner] = 1'b1;
            req_last           = req_valid;
            fifo_full          = 1'b0;
            chip_en            = 1'b1;
            cycle();
        end
        check("drain_idle", 32'(busy), 32'd0);
        req_valid = '0;
        req_last  = '0;
        cycle();
    endtask

    initial begin
        rec        = 1'b0;
        prev_grant = '0;
        clear_rec();
        model_reset();

        // Reset state, with requests and room present so ready could show up.
        rst       = 1'b1;
        chip_en   = 1'b1;
        req_valid = '1;
        req_last  = '0;
        req_data  = 32'h1234_5678;
        fifo_full = 1'b0;
        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_data", 32'(fifo_data), 32'd0);
        req_valid = '0;
        @(posedge clk_wr);
        #1;
        rst = 1'b0;

        // Single requester 1, three beats with last on the third.
        req_valid = 4'b0010;
        req_data  = 32'h0000_A100;
        cycle();
        check("t1_idle", 32'(obs_grant), 32'd0);
        req_data = 32'h0000_A100;
        req_data[15:8] = 8'hA1;
        cycle();
        check("t1_grant", 32'(obs_grant), 32'b0010);
        check("t1_beat1", 32'(obs_data), 32'hA1);
        req_data[15:8] = 8'hA2;
        cycle();
        check("t1_beat2", 32'(obs_data), 32'hA2);
        req_data[15:8] = 8'hA3;
        req_last       = 4'b0010;
        cycle();
        check("t1_beat3_we", 32'(obs_we), 32'd1);
        check("t1_beat3", 32'(obs_data), 32'hA3);
        req_valid = '0;
        req_last  = '0;
        cycle();
        check("t1_released", 32'(obs_grant), 32'd0);
        check("t1_not_busy", 32'(obs_busy), 32'd0);

        // All four valid, no last: forced release every 4 beats, rotating.
        clear_rec();
        rec       = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 21; c++) begin
            req_data = (N*W)'($urandom);
            cycle();
        end
        rec = 1'b0;
        check("t2_grants", 32'(start_q.size()), 32'd4);
        if (start_q.size() == 4) begin
            check("t2_order0", 32'(start_q[0]), 32'd2);
            check("t2_order1", 32'(start_q[1]), 32'd3);
            check("t2_order2", 32'(start_q[2]), 32'd0);
            check("t2_order3", 32'(start_q[3]), 32'd1);
        end
        for (int i = 0; i < N; i++) check("t2_beats", 32'(we_per_req[i]), 32'd4);
        check("t2_bubbles", 32'(idle_cycles), 32'd5);
        drain();

        // fifo_full for 5 cycles after beat 2 of requester 0.
        clear_rec();
        rec       = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            req_data = (N*W)'($urandom);
            cycle();
        end
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_data = (N*W)'($urandom);
            cycle();
            check("t3_full_we", 32'(obs_we), 32'd0);
            check("t3_full_ready", 32'(obs_ready), 32'd0);
            check("t3_full_grant", 32'(obs_grant), 32'b0001);
        end
        fifo_full = 1'b0;
        cycle();
        cycle();
        req_valid = '0;
        cycle();
        rec = 1'b0;
        check("t3_beats", 32'(we_per_req[0]), 32'd4);
        check("t3_released", 32'(obs_grant), 32'd0);

        // Owner 1 drops valid for 3 cycles while requester 3 waits.
        req_valid = 4'b1010;
        req_data  = (N*W)'($urandom);
        cycle();
        cycle();
        check("t4_grant", 32'(obs_grant), 32'b0010);
        req_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t4_hold", 32'(obs_grant), 32'b0010);
            check("t4_no_ready3", 32'(obs_ready[3]), 32'd0);
            check("t4_no_we", 32'(obs_we), 32'd0);
        end
        req_valid = 4'b1010;
        req_last  = 4'b0010;
        cycle();
        check("t4_last_we", 32'(obs_we), 32'd1);
        req_valid = 4'b1000;
        req_last  = '0;
        cycle();
        check("t4_bubble", 32'(obs_grant), 32'd0);
        cycle();
        check("t4_next_grant", 32'(obs_grant), 32'b1000);
        check("t4_next_ready", 32'(obs_ready), 32'b1000);
        drain();

        // Asynchronous reset during beat 2 of requester 2's burst.
        req_valid = 4'b0100;
        cycle();
        cycle();
        #1;
        rst = 1'b1;
        #1;
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_we", 32'(fifo_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk_wr);
        #1;
        rst       = 1'b0;
        req_valid = 4'b1111;
        cycle();
        cycle();
        check("t5_restart", 32'(obs_grant), 32'b0001);

        // chip_en low for 4 cycles inside owner 0's burst.
        chip_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_data = (N*W)'($urandom);
            cycle();
            check("t6_we", 32'(obs_we), 32'd0);
            check("t6_grant", 32'(obs_grant), 32'b0001);
        end
        chip_en = 1'b1;
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom & $urandom);
            req_data  = (N*W)'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            chip_en   = ($urandom_range(0, 9) != 0);
            cycle();
        end
        drain();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        check("beat_total", 32'(beat_total), 32'(m_total));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
